divisor_multiciclo: RTL and testbench

Multi-cycle restoring integer divider for the MIPS datapath. It executes DIV and DIVU by repeated shift-and-subtract, one quotient bit per cycle, and returns quotient (LO) and remainder (HI). It sits beside the ALU and is launched by the control unit, which stalls on `busy`.

---
 rtl/div_pkg.sv | 16 +
 rtl/passo_divisao.sv | 23 ++
 rtl/divisor_multiciclo.sv | 157 +++++++++++++++
 tb/tb_divisor_multiciclo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divider.
// Provides the FSM state enum, the default width and the counter width.
package div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/passo_divisao.sv
// One combinational restoring-division step.
// Ports: rem_i/q_msb_i/divisor_i in; rem_o (next remainder), q_bit_o out.
module passo_divisao #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], q_msb_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = diff[WIDTH] ? shifted : diff;
  end

endmodule

// File: rtl/divisor_multiciclo.sv
// Multi-cycle restoring divider (DIV/DIVU): quotient to LO, remainder to HI.
// Ports: clk, reset, start, signed_op, dividendo, divisor in;
//        busy, done, quociente, resto, div_zero out (all registered).
module divisor_multiciclo
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quociente,
  output logic [WIDTH-1:0] resto,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic sgn_q, sgn_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic dz_q, dz_d;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [WIDTH-1:0] rout_q, rout_d;

  logic [WIDTH:0] step_rem;
  logic           step_bit;
  logic           neg_a;
  logic           neg_b;

  passo_divisao #(.WIDTH(WIDTH)) u_passo (
    .rem_i    (rem_q),
    .q_msb_i  (quo_q[WIDTH-1]),
    .divisor_i(mag_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    mag_d   = mag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    neg_a   = sgn_q & dvd_q[WIDTH-1];
    neg_b   = sgn_q & dvs_q[WIDTH-1];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividendo;
          dvs_d   = divisor;
          sgn_d   = signed_op;
          state_d = PREP;
        end
      end
      PREP: begin
        quo_d   = neg_a ? (0 - dvd_q) : dvd_q;
        mag_d   = neg_b ? (0 - dvs_q) : dvs_q;
        negq_d  = neg_a ^ neg_b;
        negr_d  = neg_a;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1))
          state_d = FIX;
      end
      FIX: begin
        // Zero divisor: the iteration result is meaningless, override it.
        if (dvs_q == '0) begin
          qout_d = '1;
          rout_d = dvd_q;
          dz_d   = 1'b1;
        end else begin
          qout_d = negq_q ? (0 - quo_q) : quo_q;
          rout_d = negr_q ? (0 - rem_q[WIDTH-1:0])
                          : rem_q[WIDTH-1:0];
          dz_d   = 1'b0;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mag_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mag_q   <= mag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quociente = qout_q;
  assign resto     = rout_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_divisor_multiciclo.sv
// Scoreboard bench for divisor_multiciclo.
// Driver pushes expected results; monitor pops and checks on done.
module tb_divisor_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividendo;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quociente;
  logic [31:0] resto;
  logic        div_zero;

  divisor_multiciclo #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .signed_op(signed_op),
    .dividendo(dividendo),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quociente(quociente),
    .resto    (resto),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_busy_next = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_busy_next) begin
      chk_busy_next = 0;
      chk("busy_after_done", {31'b0, busy}, 32'd0);
    end
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: q=%h r=%h", quociente, resto);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quociente", quociente, e.q);
        chk("resto", resto, e.r);
        chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
        chk("latency", cyc - e.t0, 32'd34);
        chk_busy_next = 1;
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start     = 1'b1;
    signed_op = s;
    dividendo = a;
    divisor   = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL timeout: busy=%b after %0d cycles", busy, n);
    end
  endtask

  task automatic run(input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] q,
                     input logic [31:0] r, input logic dz);
    exp_t e;
    issue(s, a, b);
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    e.t0 = cyc;
    exp_q.push_back(e);
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    wait_idle();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividendo = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", quociente, 32'd0);
    chk("rst_r", resto, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    reset = 1'b0;

    run(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    run(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);
    run(1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1);
    run(0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1);
    run(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
    run(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);
    run(0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0);
    run(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 0);
    run(0, 32'hFFFFFFFF, 32'd16, 32'h0FFFFFFF, 32'd15, 0);

    begin
      exp_t e;
      issue(0, 32'd1000, 32'd10);
      e.q  = 32'd100;
      e.r  = 32'd0;
      e.dz = 0;
      e.t0 = cyc;
      exp_q.push_back(e);
      repeat (5) @(negedge clk);
      start     = 1'b1;
      signed_op = 1'b1;
      dividendo = 32'd5;
      divisor   = 32'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
    end

    issue(0, 32'd50, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_q", quociente, 32'd0);
    chk("midrst_r", resto, 32'd0);
    chk("midrst_dz", {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle", {31'b0, busy}, 32'd0);

    run(0, 32'd9, 32'd3, 32'd3, 32'd0, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
